// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, parity modes and the parity helper shared by the UART command master.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
    localparam int MAX_W    = 9;
    typedef enum logic [3:0] {
        IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, GAP,
        RX_WAIT, RX_START, RX_DATA, RX_PAR, RX_STOP, DONE
    } state_e;
    // Parity bit that completes a character for the given mode; narrower data is zero-extended.
    function automatic logic calc_parity(input logic [MAX_W-1:0] data, input int mode);
        return mode == PAR_ODD ? ~^data : mode == PAR_EVEN ? ^data : 1'b0;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-time divider, restartable for a full or half bit period.
module uart_bit_timer #(
    parameter int CLK_DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic half,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST      = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - CLK_DIV / 2);
    logic [CW-1:0] cnt_q;
    assign tick = cnt_q == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (start) cnt_q <= half ? HALF_LOAD : '0;
        else cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: sends read/write commands as framed UART characters and collects read responses.
module uart_cmd_master
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 1,
    parameter int GAP_BITS   = 2,
    parameter int RX_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*DATA_W-1:0] cmd_in,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic                rx,
    output logic                tx,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_vld,
    output logic                rd_err,
    output logic                rd_timeout
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(GAP_BITS + 2);
    localparam int TW = $clog2(RX_TIMEOUT * CLK_DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(RX_TIMEOUT * CLK_DIV - 1);
    state_e              state_q, state_d;
    logic                rw_q, rw_d, second_q, second_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, tsh_q, tsh_d, rsh_q, rsh_d, rd_data_q, rd_data_d;
    logic                tpar_q, tpar_d, rpar_q, rpar_d;
    logic [BW-1:0]       idx_q, idx_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [TW-1:0]       to_q, to_d;
    logic                rd_vld_q, rd_vld_d, rd_err_q, rd_err_d, rd_to_q, rd_to_d;
    logic                rx_meta_q, rx_sync_q, rx_prev_q;
    logic                tick, tmr_start, tmr_half;
    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tmr_start),
        .half  (tmr_half),
        .tick  (tick)
    );
    assign cmd_rdy    = state_q == IDLE;
    assign tx         = state_q == TX_START ? 1'b0 : state_q == TX_DATA ? tsh_q[0] : state_q == TX_PAR ? tpar_q : 1'b1;
    assign rd_data    = rd_data_q;
    assign rd_vld     = rd_vld_q;
    assign rd_err     = rd_err_q;
    assign rd_timeout = rd_to_q;
    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        second_d  = second_q;
        wdata_d   = wdata_q;
        tsh_d     = tsh_q;
        tpar_d    = tpar_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        to_d      = to_q;
        rsh_d     = rsh_q;
        rpar_d    = rpar_q;
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        rd_vld_d  = 1'b0;
        rd_to_d   = 1'b0;
        tmr_start = 1'b0;
        tmr_half  = 1'b0;
        case (state_q)
            IDLE: if (cmd_vld) begin
                rw_d      = cmd_in[2*DATA_W-1];
                wdata_d   = cmd_in[DATA_W-1:0];
                tsh_d     = cmd_in[2*DATA_W-1:DATA_W];
                tpar_d    = calc_parity(MAX_W'(cmd_in[2*DATA_W-1:DATA_W]), PARITY);
                second_d  = 1'b0;
                tmr_start = 1'b1;
                state_d   = TX_START;
            end
            TX_START: if (tick) begin
                idx_d   = '0;
                state_d = TX_DATA;
            end
            TX_DATA: if (tick) begin
                tsh_d = tsh_q >> 1;
                idx_d = idx_q + 1'b1;
                if (idx_q == BIT_LAST) state_d = PARITY != PAR_NONE ? TX_PAR : TX_STOP;
            end
            TX_PAR: if (tick) state_d = TX_STOP;
            TX_STOP: if (tick) begin
                if (!rw_q) begin
                    to_d    = '0;
                    state_d = RX_WAIT;
                end else if (second_q) begin
                    state_d = DONE;
                end else begin
                    tsh_d    = wdata_q;
                    tpar_d   = calc_parity(MAX_W'(wdata_q), PARITY);
                    second_d = 1'b1;
                    gap_d    = '0;
                    state_d  = GAP_BITS == 0 ? TX_START : GAP;
                end
            end
            GAP: if (tick) begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) state_d = TX_START;
            end
            // The timeout keeps running while a candidate start bit is being qualified.
            RX_WAIT, RX_START: begin
                to_d = to_q + 1'b1;
                if (to_q == TO_LAST) begin
                    rd_to_d = 1'b1;
                    state_d = IDLE;
                end else if (state_q == RX_WAIT && rx_prev_q && !rx_sync_q) begin
                    tmr_start = 1'b1;
                    tmr_half  = 1'b1;
                    state_d   = RX_START;
                end else if (state_q == RX_START && tick) begin
                    idx_d   = '0;
                    state_d = rx_sync_q ? RX_WAIT : RX_DATA;
                end
            end
            RX_DATA: if (tick) begin
                rsh_d = {rx_sync_q, rsh_q[DATA_W-1:1]};
                idx_d = idx_q + 1'b1;
                if (idx_q == BIT_LAST) state_d = PARITY != PAR_NONE ? RX_PAR : RX_STOP;
            end
            RX_PAR: if (tick) begin
                rpar_d  = rx_sync_q;
                state_d = RX_STOP;
            end
            RX_STOP: if (tick) begin
                rd_data_d = rsh_q;
                rd_err_d  = (PARITY != PAR_NONE && calc_parity(MAX_W'(rsh_q), PARITY) != rpar_q) || !rx_sync_q;
                rd_vld_d  = 1'b1;
                state_d   = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            second_q  <= 1'b0;
            wdata_q   <= '0;
            tsh_q     <= '0;
            tpar_q    <= 1'b0;
            idx_q     <= '0;
            gap_q     <= '0;
            to_q      <= '0;
            rsh_q     <= '0;
            rpar_q    <= 1'b0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_to_q   <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            second_q  <= second_d;
            wdata_q   <= wdata_d;
            tsh_q     <= tsh_d;
            tpar_q    <= tpar_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            to_q      <= to_d;
            rsh_q     <= rsh_d;
            rpar_q    <= rpar_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
            rd_vld_q  <= rd_vld_d;
            rd_to_q   <= rd_to_d;
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end
endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: randomized bench comparing the serial line against a bit-level frame model.
module tb_uart_cmd_master;
    localparam int D  = 16;
    localparam int W  = 8;
    localparam int W2 = 7;
    localparam int TO = 64;
    localparam int F  = W + 3;
    localparam int F2 = W2 + 2;
    logic            clk = 1'b0, rst_n = 1'b0;
    logic [2*W-1:0]  cmd_in = '0;
    logic            cmd_vld = 1'b0, rx = 1'b1;
    logic            cmd_rdy, tx, rd_vld, rd_err, rd_timeout;
    logic [W-1:0]    rd_data;
    logic [2*W2-1:0] cmd_in2 = '0;
    logic            cmd_vld2 = 1'b0, rx2 = 1'b1;
    logic            cmd_rdy2, tx2, rd_vld2, rd_err2, rd_timeout2;
    logic [W2-1:0]   rd_data2;
    int              checks = 0, failures = 0;
    bit              exp_q[$];
    always #5 clk = ~clk;
    uart_cmd_master #(.CLK_DIV(D), .DATA_W(W), .PARITY(1), .GAP_BITS(2), .RX_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .rx(rx), .tx(tx), .rd_data(rd_data), .rd_vld(rd_vld), .rd_err(rd_err), .rd_timeout(rd_timeout)
    );
    uart_cmd_master #(.CLK_DIV(D), .DATA_W(W2), .PARITY(0), .GAP_BITS(0), .RX_TIMEOUT(TO)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in2), .cmd_vld(cmd_vld2), .cmd_rdy(cmd_rdy2),
        .rx(rx2), .tx(tx2), .rd_data(rd_data2), .rd_vld(rd_vld2), .rd_err(rd_err2), .rd_timeout(rd_timeout2)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit par_bit(input int ch, input int w, input int pm);
        int ones;
        ones = $countones(ch & ((1 << w) - 1));
        return pm == 2 ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction
    task automatic push_frame(input int ch, input int w, input int pm);
        exp_q.push_back(1'b0);
        for (int i = 0; i < w; i++) exp_q.push_back(bit'((ch >> i) & 1));
        if (pm != 0) exp_q.push_back(par_bit(ch, w, pm));
        exp_q.push_back(1'b1);
    endtask
    // Entered on the acceptance cycle; checks every bit at its start, middle and end.
    task automatic watch_tx(input string tag, input bit noise);
        for (int k = 0; k < exp_q.size() * D; k++) begin
            @(negedge clk);
            if (k == 0) begin
                cmd_vld = 1'b0;
                check({tag, "_rdy_low"}, cmd_rdy, 0);
            end
            if (k % D == 0 || k % D == D / 2 || k % D == D - 1) check(tag, tx, exp_q[k / D]);
            rx = noise ? 1'($urandom) : 1'b1;
        end
        rx = 1'b1;
    endtask
    task automatic do_write(input logic [2*W-1:0] cmd, input bit noise);
        int c;
        exp_q.delete();
        push_frame(cmd[2*W-1:W], W, 1);
        repeat (2) exp_q.push_back(1'b1);
        push_frame(cmd[W-1:0], W, 1);
        @(negedge clk);
        check("wr_rdy_before", cmd_rdy, 1);
        cmd_in  = cmd;
        cmd_vld = 1'b1;
        watch_tx("wr_tx", noise);
        c = exp_q.size() * D - 1;
        while (!cmd_rdy && c < exp_q.size() * D + 20) begin
            @(negedge clk);
            c++;
        end
        check("wr_duration", c + 1, 2 * F * D + 2 * D + 2);
    endtask
    task automatic do_read(input logic [W-2:0] addr, input logic [W-1:0] data, input int kind);
        int hit;
        exp_q.delete();
        push_frame({1'b0, addr}, W, 1);
        @(negedge clk);
        check("rd_rdy_before", cmd_rdy, 1);
        cmd_in  = {1'b0, addr, W'($urandom)};
        cmd_vld = 1'b1;
        watch_tx("rd_cmd_tx", 1'b0);
        exp_q.delete();
        push_frame(data, W, 1);
        if (kind == 1) exp_q[W+1] = ~exp_q[W+1];
        if (kind == 2) exp_q[W+2] = 1'b0;
        repeat ($urandom_range(0, 3 * D)) @(negedge clk);
        hit = -1;
        for (int c = 0; c < (exp_q.size() + 1) * D && hit < 0; c++) begin
            rx = c / D < exp_q.size() ? exp_q[c / D] : 1'b1;
            @(negedge clk);
            if (rd_vld) hit = c;
        end
        rx = 1'b1;
        check("rd_vld_seen", hit >= 0, 1);
        if (hit >= 0) begin
            check("rd_vld_in_stop_bit", hit / D, exp_q.size() - 1);
            check("rd_data", rd_data, data);
            check("rd_err", rd_err, kind != 0);
            check("rd_rdy_low_at_vld", cmd_rdy, 0);
            @(negedge clk);
            check("rd_vld_pulse", rd_vld, 0);
            check("rd_rdy_after", cmd_rdy, 1);
        end
    endtask
    task automatic do_timeout(input bit glitch);
        int g, hit;
        bit seen_vld;
        exp_q.delete();
        push_frame({1'b0, 7'h55}, W, 1);
        @(negedge clk);
        cmd_in  = {1'b0, 7'h55, 8'h00};
        cmd_vld = 1'b1;
        watch_tx("to_cmd_tx", 1'b0);
        g        = glitch ? $urandom_range(50, 900) : -1;
        hit      = -1;
        seen_vld = 1'b0;
        for (int c = F * D; c < F * D + TO * D + 50 && hit < 0; c++) begin
            @(negedge clk);
            if (rd_vld) seen_vld = 1'b1;
            if (rd_timeout) hit = c;
            rx = (g >= 0 && c >= F * D + g && c < F * D + g + 3) ? 1'b0 : 1'b1;
        end
        rx = 1'b1;
        check(glitch ? "to_cycle_glitch" : "to_cycle", hit, F * D + TO * D);
        check("to_no_vld", seen_vld, 0);
        @(negedge clk);
        check("to_pulse", rd_timeout, 0);
        check("to_rdy", cmd_rdy, 1);
    endtask
    task automatic reset_mid_write();
        logic [2*W-1:0] cmd;
        cmd = {1'b1, 15'($urandom)};
        @(negedge clk);
        cmd_in  = cmd;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        repeat ((F + 2 + 4) * D + D / 2) @(negedge clk);
        check("rst_data_bit3", tx, cmd[3]);
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_rdy", cmd_rdy, 1);
        check("rst_outputs", {rd_vld, rd_err, rd_timeout, rd_data}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic sweep();
        logic [2*W2-1:0] cmds[3];
        int cyc, last, guard;
        for (int i = 0; i < 3; i++) cmds[i] = {1'b1, 13'($urandom)};
        @(negedge clk);
        cmd_in2  = cmds[0];
        cmd_vld2 = 1'b1;
        cyc      = 0;
        last     = 0;
        for (int i = 0; i < 3; i++) begin
            guard = 0;
            while (!cmd_rdy2 && guard < 20) begin
                @(negedge clk);
                cyc++;
                guard++;
            end
            check("sw_accept", cmd_rdy2, 1);
            if (i > 0) check("sw_period", cyc - last, 2 * F2 * D + 2);
            last = cyc;
            exp_q.delete();
            push_frame(cmds[i][2*W2-1:W2], W2, 0);
            push_frame(cmds[i][W2-1:0], W2, 0);
            for (int k = 0; k < exp_q.size() * D; k++) begin
                @(negedge clk);
                cyc++;
                if (k == 0) begin
                    if (i < 2) cmd_in2 = cmds[i+1];
                    else cmd_vld2 = 1'b0;
                end
                if (k % D == D / 2) check("sw_tx", tx2, exp_q[k / D]);
            end
        end
        check("sw_no_read", {rd_vld2, rd_err2, rd_timeout2, rd_data2}, 0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_rdy", cmd_rdy, 1);
        check("reset_outputs", {rd_vld, rd_err, rd_timeout, rd_data}, 0);
        check("reset_tx2", {tx2, cmd_rdy2}, 2'b11);
        rst_n = 1'b1;
        @(negedge clk);
        do_write(16'h8A5C, 1'b0);
        repeat (3) do_write({1'b1, 15'($urandom)}, 1'b1);
        do_read(7'h03, 8'hA5, 0);
        repeat (3) do_read(7'($urandom), 8'($urandom), 0);
        do_read(7'h03, 8'hA5, 1);
        do_read(7'($urandom), 8'($urandom), 2);
        do_timeout(1'b0);
        do_timeout(1'b1);
        reset_mid_write();
        do_write({1'b1, 15'($urandom)}, 1'b0);
        sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end
endmodule
